// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a word-only data memory. Stores are queued and
// retired by read-modify-write when the port is free. Optional macro: STORE_BUF_COALESCE_EN.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wd,
   input  logic [2:0]  req_ctrl,
   output logic [31:0] rd,
   output logic        stall,
   output logic        misalign,
   output logic        empty,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic [2:0]  mem_ctrl,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] valid_reg;
   logic [29:0]      addr_reg [DEPTH];
   logic [31:0]      data_reg [DEPTH];
   logic [3:0]       mask_reg [DEPTH];
   logic [PW-1:0]    head_reg;
   logic [PW-1:0]    tail_reg;
   logic [CW-1:0]    count_reg;

   logic [1:0]       size;
   logic             zext;
   logic [29:0]      word_addr;
   logic [1:0]       lane;
   logic             misalign_c;
   logic [DEPTH-1:0] hit_vec;
   logic             full;
   logic             merge;
   logic             active;
   logic             stall_c;
   logic             accept;
   logic             push;
   logic             drain;
   logic [31:0]      st_data;
   logic [3:0]       st_mask;
   logic [31:0]      drain_m;
   logic [31:0]      drain_wd;
   logic [31:0]      shifted;
   logic [31:0]      ld_data;

   assign size      = req_ctrl[1:0];
   assign zext      = req_ctrl[2];
   assign word_addr = req_addr[31:2];
   assign lane      = req_addr[1:0];
   assign full      = (count_reg == CW'(DEPTH));

   assign misalign_c = req_valid && (((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00)));

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign hit_vec[gi] = valid_reg[gi] && (addr_reg[gi] == word_addr);
      end
   endgenerate

`ifdef STORE_BUF_COALESCE_EN
   logic [PW-1:0] tail_last;
   logic [31:0]   merged_data;
   assign tail_last = tail_reg - PW'(1);
   assign merge     = (count_reg != '0) && valid_reg[tail_last] && (addr_reg[tail_last] == word_addr);
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merged_data[8*gi +: 8] = st_mask[gi] ? st_data[8*gi +: 8] : data_reg[tail_last][8*gi +: 8];
      end
   endgenerate
`else
   assign merge = 1'b0;
`endif

   // A store never stalls when it can fold into the newest entry, even with the FIFO full.
   assign active  = reset_n && req_valid && !misalign_c;
   assign stall_c = active && (req_we ? (full && !merge) : (|hit_vec));
   assign accept  = active && !stall_c;
   assign push    = accept && req_we && !merge;
   assign drain   = reset_n && (count_reg != '0) && (!req_valid || stall_c);

   always_comb begin
      st_data = req_wd;
      st_mask = 4'b1111;
      case (size)
         2'b00: begin
            st_data = {4{req_wd[7:0]}};
            st_mask = 4'b0001 << lane;
         end
         2'b01: begin
            st_data = {2{req_wd[15:0]}};
            st_mask = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_expand
         assign drain_m[8*gi +: 8] = {8{mask_reg[head_reg][gi]}};
      end
   endgenerate
   assign drain_wd = (mem_rd & ~drain_m) | (data_reg[head_reg] & drain_m);

   always_comb begin
      shifted = mem_rd >> {lane, 3'b000};
      case (size)
         2'b00:   ld_data = zext ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ld_data = zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data = mem_rd;
      endcase
   end

   assign rd       = (accept && !req_we) ? ld_data : 32'h0;
   assign stall    = stall_c;
   assign misalign = reset_n && misalign_c;
   assign empty    = (count_reg == '0);
   assign mem_ctrl = 3'b010;
   assign mem_we   = drain;
   assign mem_a    = drain ? {addr_reg[head_reg], 2'b00} : {word_addr, 2'b00};
   assign mem_wd   = drain ? drain_wd : 32'h0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_reg <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
`ifdef STORE_BUF_COALESCE_EN
         if (accept && req_we && merge) begin
            data_reg[tail_last] <= merged_data;
            mask_reg[tail_last] <= mask_reg[tail_last] | st_mask;
         end
`endif
         if (push) begin
            valid_reg[tail_reg] <= 1'b1;
            addr_reg[tail_reg]  <= word_addr;
            data_reg[tail_reg]  <= st_data;
            mask_reg[tail_reg]  <= st_mask;
            tail_reg            <= tail_reg + PW'(1);
         end
         if (drain) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + PW'(1);
         end
         count_reg <= count_reg + CW'(push) - CW'(drain);
      end
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Load/store unit between the MEM pipeline stage and the data memory. Queues stores (including sb/sh with byte masks) in a small FIFO and retires them to the word-only memory port by read-modify-write in cycles when the MEM stage makes no memory request. Loads read the memory port directly and are lane-selected and sign/zero-extended here, stalling only when they hit a pending store. The memory port is always driven with word-size control.

## Interface
- DEPTH, 4: store FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage presents a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wd  in  32  store data, right-aligned.
- req_ctrl  in  3  {u, size}; size 00 byte, 01 half, 10 word; u = zero-extend load.
- rd  out  32  extended load data (combinational).
- stall  out  1  request not accepted this cycle; hold request stable.
- misalign  out  1  request misaligned; access suppressed.
- empty  out  1  no pending stores.
- mem_a  out  32  memory byte address (bits 1:0 always 0).
- mem_wd  out  32  memory write data.
- mem_ctrl  out  3  always 3'b010.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  memory read data (asynchronous).

## Operation
- Entry: valid, word address (addr[31:2]), data[31:0], mask[3:0]. Circular FIFO, head/tail pointers, count 0..DEPTH.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned: misalign=1, stall=0, no enqueue, no memory write, rd=0. Request is consumed (dropped).
- Store lane placement: byte → req_wd[7:0] into lane addr[1:0], mask 1<<addr[1:0]; half → req_wd[15:0] into lanes {addr[1],0}, mask 0011 or 1100; word → mask 1111.
- Store accept: count<DEPTH → enqueue at tail; count==DEPTH → stall=1.
- Load hit: word address equals any valid entry → stall=1.
- Load miss: mem_a={addr[31:2],2'b00}, mem_we=0; rd = lane(s) of mem_rd selected by addr[1:0], extended per u/size; word ignores u.
- Drain: occurs when count>0 and (req_valid=0 or stall=1). mem_a=head address, mem_wd=(mem_rd & ~m) | (data & m) with m = byte-expanded mask, mem_we=1; head pops at the edge. Otherwise mem_we=0.
- Accepted requests never drain in the same cycle; port belongs to the request.
- Repeated stalls drain one entry per cycle until the hit clears or a slot frees. Load worst-case stall: DEPTH cycles.
- empty = (count==0).

## Timing
- rd, stall, misalign, mem_* combinational from request and state; zero-cycle load latency on miss.
- Store visible in memory at earliest on the edge ending the first no-request/stall cycle after enqueue.
- Reset (reset_n=0 at edge): count=0, pointers=0, all entries invalid. While reset_n=0: stall=0, mem_we=0, misalign=0, rd=0, empty reflects count. Reset mid-operation discards pending stores; no partial write is issued.
- Back-to-back stores: one accepted per cycle until full.

## Configuration
- STORE_BUF_COALESCE_EN defined: an accepted store whose word address equals the tail (newest valid) entry merges into it: data lanes overwritten per new mask, mask OR-ed. No count change, no stall even when full. Only the tail is eligible.
- Undefined: every accepted store enqueues a new entry.

## Test plan
- sw 0x11223344 @0x8, then idle -> next cycle mem_we=1, mem_a=0x8, mem_wd=0x11223344; empty=1 after edge.
- Memory word 0x8 = 0xAABBCCDD; sb 0x5A @0x9, idle -> drain writes 0xAABB5ADD.
- Memory word 0x8 = 0x80FF0000, empty: lb @0xB -> rd=0xFFFFFF80; lbu @0xB -> 0x00000080; lh @0xA -> 0xFFFF80FF; lhu @0xA -> 0x000080FF.
- DEPTH=4: sw to 0x0,0x4,0x8,0xC back-to-back, then sw @0x10 -> stall=1 one cycle with mem_we=1, mem_a=0x0; accepted next cycle; lw @0x42 -> misalign=1, mem_we=0, count unchanged.
- Pending sw 0xDEADBEEF @0x40, lw @0x40 -> stall=1, drain to 0x40, next cycle stall=0, rd=0xDEADBEEF.
- sb 0x11 @0x20 then sb 0x22 @0x21 back-to-back, idle, memory 0 -> with STORE_BUF_COALESCE_EN one drain writing 0x00002211; without, two drains (0x00000011 then 0x00002211). Reset asserted with 2 pending -> no mem_we, empty=1.
